// File: rtl/write_word_buffer_if.sv
// Write-beat input channel, word output channel and status of the write word buffer.
// The buffer uses the slave side of this interface and its traffic source uses the master side.
interface write_word_buffer_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [3:0]        in_strb;
    logic [ADDR_W-1:0] in_addr;
    logic              in_last;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-3:0] out_waddr;
    logic [31:0]       out_data;
    logic [3:0]        out_mask;
    logic              busy;

    modport master (
        output in_valid, in_data, in_strb, in_addr, in_last, flush, out_ready,
        input  in_ready, out_valid, out_waddr, out_data, out_mask, busy
    );

    modport slave (
        input  in_valid, in_data, in_strb, in_addr, in_last, flush, out_ready,
        output in_ready, out_valid, out_waddr, out_data, out_mask, busy
    );
endinterface

// File: rtl/write_word_buffer.sv
// Merges byte-lane write beats into whole 32-bit words in an accumulator and queues
// the completed words in a small FIFO. Up to two words can be pushed in one cycle.
module write_word_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input logic                clk,
    input logic                rst,
    write_word_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [PTR_W:0] OCC_FULL      = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] OCC_READY_MAX = (PTR_W + 1)'(DEPTH - 2);

    function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = base;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
        end
        return r;
    endfunction

    logic            acc_valid;
    logic [WA_W-1:0] acc_waddr;
    logic [31:0]     acc_data;
    logic [3:0]      acc_mask;

    logic [WA_W-1:0] mem_waddr [DEPTH];
    logic [31:0]     mem_data  [DEPTH];
    logic [3:0]      mem_mask  [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_idx_b;
    logic [PTR_W:0]   occ, n_push;
    logic             ready, head_valid, accept, pop, has_strb, same_word;
    logic             push_a, push_b, clear_acc, load_acc;
    logic [WA_W-1:0]  beat_waddr;
    logic [31:0]      base_data, merged_data;
    logic [3:0]       base_mask, merged_mask;

    // Unmasked accumulator lanes are kept at zero, so a fresh word starts from an all-zero base.
    always_comb begin
        ready       = (occ <= OCC_READY_MAX);
        head_valid  = (occ != '0);
        accept      = bus.in_valid && ready;
        pop         = head_valid && bus.out_ready;
        beat_waddr  = bus.in_addr[ADDR_W-1:2];
        has_strb    = (bus.in_strb != 4'b0000);
        same_word   = !acc_valid || (acc_waddr == beat_waddr);
        base_data   = (acc_valid && same_word) ? acc_data : 32'h0;
        base_mask   = (acc_valid && same_word) ? acc_mask : 4'b0000;
        merged_data = merge_lanes(base_data, bus.in_data, bus.in_strb);
        merged_mask = base_mask | bus.in_strb;

        push_a    = 1'b0;
        push_b    = 1'b0;
        clear_acc = 1'b0;
        load_acc  = 1'b0;
        if (accept) begin
            if (has_strb) begin
                push_a = acc_valid && !same_word;
                if (merged_mask == 4'b1111 || bus.in_last) begin
                    push_b    = 1'b1;
                    clear_acc = 1'b1;
                end else begin
                    load_acc = 1'b1;
                end
            end else if (bus.in_last && acc_valid) begin
                push_a    = 1'b1;
                clear_acc = 1'b1;
            end
        end else if (bus.flush && acc_valid && occ != OCC_FULL) begin
            push_a    = 1'b1;
            clear_acc = 1'b1;
        end

        n_push   = (PTR_W + 1)'(push_a) + (PTR_W + 1)'(push_b);
        wr_idx_b = push_a ? wr_ptr + PTR_W'(1) : wr_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            acc_valid <= 1'b0;
            acc_waddr <= '0;
            acc_data  <= 32'h0;
            acc_mask  <= 4'b0000;
        end else begin
            occ    <= occ + n_push - (PTR_W + 1)'(pop);
            wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop);
            if (clear_acc) begin
                acc_valid <= 1'b0;
                acc_data  <= 32'h0;
                acc_mask  <= 4'b0000;
            end else if (load_acc) begin
                acc_valid <= 1'b1;
                acc_waddr <= beat_waddr;
                acc_data  <= merged_data;
                acc_mask  <= merged_mask;
            end
        end
    end

    // The older accumulator word always lands in the lower slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push_a) begin
                mem_waddr[wr_ptr] <= acc_waddr;
                mem_data[wr_ptr]  <= acc_data;
                mem_mask[wr_ptr]  <= acc_mask;
            end
            if (push_b) begin
                mem_waddr[wr_idx_b] <= beat_waddr;
                mem_data[wr_idx_b]  <= merged_data;
                mem_mask[wr_idx_b]  <= merged_mask;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = head_valid;
    assign bus.out_waddr = head_valid ? mem_waddr[rd_ptr] : '0;
    assign bus.out_data  = head_valid ? mem_data[rd_ptr] : 32'h0;
    assign bus.out_mask  = head_valid ? mem_mask[rd_ptr] : 4'b0000;
    assign bus.busy      = acc_valid || head_valid;
endmodule
